// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - pipelined WIDTH-bit adder/subtractor with valid/ready handshake
//
// Purpose: resolves the carry chain CHUNK bits per pipeline stage, so wide adds
// close timing. Subtraction is A + ~B + 1. The whole pipe freezes on backpressure.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand beat handshake (in_ready = !out_valid || out_ready)
//   a, b                 operands, WIDTH bits
//   carry_in             carry into bit 0 (add mode only)
//   sub                  1 = a - b, 0 = a + b + carry_in
//   out_valid/out_ready  result beat handshake
//   sum                  result modulo 2^WIDTH
//   carry_out            carry out of MSB (subtract: 1 = no borrow)
//   overflow             signed overflow (carry into MSB ^ carry out of MSB)
module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;
  // Operand skew registers exist only between stages; keep at least one entry
  // so the array stays legal when the pipe is a single stage.
  localparam int NSKEW  = (STAGES > 1) ? STAGES - 1 : 1;

  logic adv;

  // Values presented to each stage's adder (stage 0 sees the ports directly).
  logic [WIDTH-1:0] stg_a     [STAGES];
  logic [WIDTH-1:0] stg_b     [STAGES];
  logic [WIDTH-1:0] stg_part  [STAGES];
  logic             stg_carry [STAGES];
  logic             stg_valid [STAGES];

  logic [CHUNK:0]   chunk_sum [STAGES];
  logic [WIDTH-1:0] part_d    [STAGES];
  logic             carry_d   [STAGES];
  logic             msb_carry_d;
  logic             ovf_d;

  logic             valid_q   [STAGES];
  logic [WIDTH-1:0] part_q    [STAGES];
  logic             carry_q   [STAGES];
  logic [WIDTH-1:0] op_a_q    [NSKEW];
  logic [WIDTH-1:0] op_b_q    [NSKEW];
  logic             ovf_q;

  // Freeze everything while a result is waiting on the consumer.
  assign adv       = !valid_q[LAST] || out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[LAST];
  assign sum       = part_q[LAST];
  assign carry_out = carry_q[LAST];
  assign overflow  = ovf_q;

  always_comb begin
    stg_a[0]     = a;
    stg_b[0]     = sub ? ~b : b;
    stg_part[0]  = '0;
    stg_carry[0] = sub | carry_in;
    stg_valid[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      stg_a[k]     = op_a_q[k-1];
      stg_b[k]     = op_b_q[k-1];
      stg_part[k]  = part_q[k-1];
      stg_carry[k] = carry_q[k-1];
      stg_valid[k] = valid_q[k-1];
    end

    // Stage k fills in result chunk k; lower chunks ride along so every chunk
    // of a beat leaves the last stage together.
    for (int k = 0; k < STAGES; k++) begin
      chunk_sum[k] = {1'b0, stg_a[k][k*CHUNK +: CHUNK]}
                   + {1'b0, stg_b[k][k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, stg_carry[k]};
      part_d[k]    = stg_part[k];
      part_d[k][k*CHUNK +: CHUNK] = chunk_sum[k][CHUNK-1:0];
      carry_d[k]   = chunk_sum[k][CHUNK];
    end

    // Sum bit = a ^ b ^ carry_in_of_bit, so the carry into the MSB falls out
    // of the MSB operand and result bits.
    msb_carry_d = stg_a[LAST][WIDTH-1] ^ stg_b[LAST][WIDTH-1] ^ part_d[LAST][WIDTH-1];
    ovf_d       = msb_carry_d ^ carry_d[LAST];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        part_q[k]  <= '0;
        carry_q[k] <= 1'b0;
      end
      for (int j = 0; j < NSKEW; j++) begin
        op_a_q[j] <= '0;
        op_b_q[j] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < LAST; k++) begin
        valid_q[k] <= stg_valid[k];
        part_q[k]  <= part_d[k];
        carry_q[k] <= carry_d[k];
        op_a_q[k]  <= stg_a[k];
        op_b_q[k]  <= stg_b[k];
      end
      valid_q[LAST] <= stg_valid[LAST];
      // Output registers only load real beats so they hold the last result
      // across bubbles.
      if (stg_valid[LAST]) begin
        part_q[LAST]  <= part_d[LAST];
        carry_q[LAST] <= carry_d[LAST];
        ovf_q         <= ovf_d;
      end
    end
  end

endmodule
